// File: rtl/isa_pkg.sv
// Shared instruction-set definitions: word width, halt encoding, loader FSM states, error codes.
package isa_pkg;

  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_FORMAT   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/instr_loader.sv
// Assembles byte-pairs into 9-bit instructions and writes them to sequential memory addresses.
// Latency: one write cycle after the high byte is accepted; at least 3 cycles per instruction.
// Backpressure: in_ready is high only while waiting for a byte (LO/HI); bytes are held by the source otherwise.
module instr_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output logic [ADDR_W:0]    count
);

  loader_state_t state, state_nxt;

  logic [ADDR_W-1:0]  addr;
  logic [7:0]         lo_byte;
  logic               hi_bit;
  logic [1:0]         err_q;
  logic [ADDR_W:0]    count_q;
  logic               xfer;
  logic               last_addr;
  logic               hi_bad;
  logic [INSTR_W-1:0] word;

  assign xfer      = in_valid && in_ready;
  assign last_addr = &addr;
  assign hi_bad    = in_byte[7:1] != 7'd0;
  assign word      = {hi_bit, lo_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        done = (state == ST_DONE);
        if (start) state_nxt = ST_LO;
      end
      ST_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = ST_HI;
      end
      ST_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = hi_bad ? ST_ERROR : ST_WRITE;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (word == HALT_WORD) state_nxt = ST_DONE;
        else if (last_addr)    state_nxt = ST_ERROR;
        else                   state_nxt = ST_LO;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers; a reset mid-load wipes the partially assembled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      lo_byte <= '0;
      hi_bit  <= 1'b0;
      err_q   <= ERR_NONE;
      count_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            addr    <= '0;
            count_q <= '0;
            err_q   <= ERR_NONE;
          end
        end
        ST_LO: begin
          if (xfer) lo_byte <= in_byte;
        end
        ST_HI: begin
          if (xfer) begin
            if (hi_bad) err_q  <= ERR_FORMAT;
            else        hi_bit <= in_byte[0];
          end
        end
        ST_WRITE: begin
          count_q <= count_q + 1'b1;
          if (word != HALT_WORD) begin
            if (last_addr) err_q <= ERR_OVERFLOW;
            else           addr  <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_addr = addr;
  assign wr_data = wr_en ? word : '0;
  assign err     = err_q;
  assign count   = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader: a word-level program model predicts writes and final status.
module tb_instr_loader;
  import isa_pkg::*;

  localparam int AW_A = 10;
  localparam int AW_B = 2;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start_a  = 1'b0;
  logic       start_b  = 1'b0;
  logic [7:0] in_byte  = '0;
  logic       in_valid = 1'b0;

  logic            ready_a, wr_en_a, busy_a, done_a;
  logic [AW_A-1:0] addr_a;
  logic [8:0]      data_a;
  logic [1:0]      err_a;
  logic [AW_A:0]   count_a;

  logic            ready_b, wr_en_b, busy_b, done_b;
  logic [AW_B-1:0] addr_b;
  logic [8:0]      data_b;
  logic [1:0]      err_b;
  logic [AW_B:0]   count_b;

  instr_loader #(.ADDR_W(AW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(ready_a), .wr_en(wr_en_a), .wr_addr(addr_a), .wr_data(data_a),
    .busy(busy_a), .done(done_a), .err(err_a), .count(count_a)
  );

  instr_loader #(.ADDR_W(AW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(ready_b), .wr_en(wr_en_b), .wr_addr(addr_b), .wr_data(data_b),
    .busy(busy_b), .done(done_b), .err(err_b), .count(count_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en_a) wr_cnt_a <= wr_cnt_a + 1;
    if (wr_en_b) wr_cnt_b <= wr_cnt_b + 1;
  end

  // Only one instance is started at a time; the other sits idle and ignores the shared byte bus.
  logic        sel_b = 1'b0;
  logic        s_ready, s_wr_en, s_busy, s_done;
  logic [9:0]  s_addr;
  logic [8:0]  s_data;
  logic [1:0]  s_err;
  logic [10:0] s_count;

  assign s_ready = sel_b ? ready_b : ready_a;
  assign s_wr_en = sel_b ? wr_en_b : wr_en_a;
  assign s_busy  = sel_b ? busy_b  : busy_a;
  assign s_done  = sel_b ? done_b  : done_a;
  assign s_addr  = sel_b ? {8'd0, addr_b} : addr_a;
  assign s_data  = sel_b ? data_b  : data_a;
  assign s_err   = sel_b ? err_b   : err_a;
  assign s_count = sel_b ? {8'd0, count_b} : count_a;

  logic [7:0] prog_lo[$];
  logic [7:0] prog_hi[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_word(input logic [8:0] w);
    prog_lo.push_back(w[7:0]);
    prog_hi.push_back({7'd0, w[8]});
  endtask

  task automatic gen_random(input int max_len);
    int len;
    logic [8:0] w;
    logic [6:0] junk;
    prog_lo.delete();
    prog_hi.delete();
    len = $urandom_range(1, max_len);
    for (int k = 0; k < len - 1; k++) begin
      w = 9'($urandom_range(0, 510));
      add_word(w);
      if ($urandom_range(0, 9) == 0) begin
        junk = 7'($urandom_range(1, 127));
        prog_hi[k] = {junk, w[8]};
      end
    end
    add_word(HALT_WORD);
  endtask

  // Drives the current program into the selected instance and checks every write and the final status.
  task automatic run_load(input bit use_b, input int vmode, input bit mid_start);
    int         cap, exp_n, exp_bytes, mid, wa0, wb0;
    logic [1:0] exp_err;
    bit         exp_done, acc, v, good;
    logic [7:0] bv;

    cap      = use_b ? (1 << AW_B) : (1 << AW_A);
    exp_n    = 0;
    exp_err  = ERR_NONE;
    exp_done = 1'b0;
    for (int k = 0; k < prog_lo.size(); k++) begin
      if (prog_hi[k][7:1] != 7'd0) begin exp_err = ERR_FORMAT; break; end
      exp_n++;
      if ({prog_hi[k][0], prog_lo[k]} == HALT_WORD) begin exp_done = 1'b1; break; end
      if (k == cap - 1) begin exp_err = ERR_OVERFLOW; break; end
    end
    exp_bytes = (exp_err == ERR_FORMAT) ? 2 * exp_n + 2 : 2 * exp_n;
    mid = mid_start ? $urandom_range(1, exp_bytes - 1) : -1;

    wa0   = wr_cnt_a;
    wb0   = wr_cnt_b;
    sel_b = use_b;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check_eq("start_busy",  s_busy,  1);
    check_eq("start_count", s_count, 0);
    check_eq("start_err",   s_err,   ERR_NONE);
    check_eq("start_done",  s_done,  0);

    for (int b = 0; b < exp_bytes; b++) begin
      bv  = b[0] ? prog_hi[b / 2] : prog_lo[b / 2];
      acc = 1'b0;
      for (int g = 0; g < 40 && !acc; g++) begin
        case (vmode)
          0:       v = 1'($urandom_range(0, 1));
          1:       v = cyc[0];
          default: v = 1'b1;
        endcase
        in_valid = v;
        in_byte  = v ? bv : 8'($urandom);
        if (use_b) start_b = (b == mid && g == 0);
        else       start_a = (b == mid && g == 0);
        acc = v && s_ready;
        @(negedge clk);
      end
      start_a = 1'b0;
      start_b = 1'b0;
      check_eq("byte_accepted", acc, 1);
      if (acc && b[0]) begin
        good = prog_hi[b / 2][7:1] == 7'd0;
        check_eq("wr_en_after_hi", s_wr_en, good);
        if (good) begin
          check_eq("wr_addr", s_addr, b / 2);
          check_eq("wr_data", s_data, {prog_hi[b / 2][0], prog_lo[b / 2]});
        end else begin
          check_eq("fmt_err_now", s_err, ERR_FORMAT);
        end
      end
    end

    // Bytes offered after the load ends must be ignored.
    in_valid = 1'b1;
    in_byte  = 8'($urandom);
    @(negedge clk);
    in_byte  = 8'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("end_done",   s_done,  exp_done);
    check_eq("end_err",    s_err,   exp_err);
    check_eq("end_count",  s_count, exp_n);
    check_eq("end_busy",   s_busy,  0);
    check_eq("end_ready",  s_ready, 0);
    check_eq("end_wr_en",  s_wr_en, 0);
    check_eq("n_writes",   use_b ? wr_cnt_b - wb0 : wr_cnt_a - wa0, exp_n);
    check_eq("idle_writes", use_b ? wr_cnt_a - wa0 : wr_cnt_b - wb0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, s_ready, 0);
    check_eq({tag, "_wr_en"}, s_wr_en, 0);
    check_eq({tag, "_addr"},  s_addr,  0);
    check_eq({tag, "_data"},  s_data,  0);
    check_eq({tag, "_busy"},  s_busy,  0);
    check_eq({tag, "_done"},  s_done,  0);
    check_eq({tag, "_err"},   s_err,   0);
    check_eq({tag, "_count"}, s_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wa0;
    #1;
    check_reset_outputs("rst_a");
    sel_b = 1'b1;
    #1;
    check_reset_outputs("rst_b");
    sel_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Halt-only program.
    prog_lo.delete(); prog_hi.delete();
    add_word(9'h1FF);
    run_load(1'b0, 2, 1'b0);

    // Three-word program.
    prog_lo.delete(); prog_hi.delete();
    add_word(9'h005); add_word(9'h134); add_word(9'h1FF);
    run_load(1'b0, 2, 1'b0);

    // Format error on the first high byte.
    prog_lo.delete(); prog_hi.delete();
    prog_lo.push_back(8'h12); prog_hi.push_back(8'h02);
    run_load(1'b0, 2, 1'b0);

    // Overflow on the 4-word instance.
    prog_lo.delete(); prog_hi.delete();
    add_word(9'h011); add_word(9'h122); add_word(9'h033); add_word(9'h144); add_word(9'h1FF);
    run_load(1'b1, 2, 1'b0);

    // Alternating valid.
    gen_random(6);
    run_load(1'b0, 1, 1'b0);

    // Reset after only a low byte, then a clean reload.
    sel_b = 1'b0;
    wa0   = wr_cnt_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_writes", wr_cnt_a - wa0, 0);
    prog_lo.delete(); prog_hi.delete();
    add_word(9'h0AB); add_word(9'h1FF);
    run_load(1'b0, 0, 1'b0);

    // Start pulsed mid-load must be ignored.
    prog_lo.delete(); prog_hi.delete();
    add_word(9'h101); add_word(9'h002); add_word(9'h103); add_word(9'h1FF);
    run_load(1'b0, 0, 1'b1);

    for (int it = 0; it < 30; it++) begin
      bit ub;
      ub = 1'($urandom_range(0, 1));
      gen_random(ub ? 7 : 8);
      run_load(ub, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
